note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Upstream feeder for the tone generator that drives the speaker pin.
- Steps through a fixed melody ROM. For each note it presents a half-period divisor and a tone enable for a programmed number of beats, followed by a short silent gap between notes.
- The tone generator toggles the speaker every half_period clocks while tone_en is high.

Parameters:
- BEAT_CYC, 25_000_000: clocks per beat (250 ms at 100 MHz); benches use 4.
- GAP_CYC, 2_000_000: silent clocks inserted after every note; benches use 2; 0 means no gap state.
- SONG_LEN, 16: number of ROM entries played, 1..16.
- DIV_W, 18: width of the half-period divisor.
- LOOP, 0: 1 means restart at entry 0 after the last entry instead of finishing.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin playback; ignored while busy
- stop  in  1  abort playback; wins over start in the same cycle
- half_period  out  DIV_W  divisor for the tone generator; 0 when silent
- tone_en  out  1  tone generator enable
- busy  out  1  high from LOAD through GAP
- note_idx  out  4  current ROM index
- done  out  1  one-cycle pulse when the song completes (LOOP=0 only)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: state=IDLE, half_period=0, tone_en=0, busy=0, note_idx=0, done=0, beat and cycle counters=0.
- ROM entry format (7 bits): note[3:0], dur[2:0].
  - note 0 = rest; 1..12 = C4..B4.
  - dur = beats; dur 0 is treated as 1.
- States:
  - IDLE: outputs silent. start=1 and stop=0 → LOAD; note_idx←0.
  - LOAD, one cycle: registered ROM fetch of note_idx; latch divisor and dur → PLAY.
  - PLAY:
    - half_period = table[note]. tone_en=1 if note≠0, else tone_en=0 and half_period=0; timing is identical for rests.
    - Lasts exactly dur×BEAT_CYC cycles, then → GAP (→ NEXT if GAP_CYC=0).
  - GAP: tone_en=0, half_period=0 for exactly GAP_CYC cycles → NEXT.
  - NEXT, one cycle:
    - If note_idx==SONG_LEN-1: with LOOP=1, note_idx←0 → LOAD; with LOOP=0, done=1 for this cycle → IDLE.
    - Otherwise note_idx+1 → LOAD.
- Latency:
  - start seen at edge N → LOAD during cycle N+1 → tone_en=1 from edge N+2.
  - Per-note period = 1 (LOAD) + dur×BEAT_CYC + GAP_CYC + 1 (NEXT).
- stop=1 in any state: next edge → IDLE, tone_en=0, half_period=0, busy=0, note_idx=0, no done pulse.
- start while busy: no effect.
- Counters:
  - beat_cnt counts 0..BEAT_CYC-1; beats_left counts down from dur.
  - gap_cnt is ⌈log2(GAP_CYC+1)⌉ bits.
  - No counter wraps silently; all are reset on every LOAD.
- Outputs are registered; half_period and tone_en change only on state transitions.
- rst_n low mid-note: identical to reset; tone silenced on the next edge.

Decomposition:
- Package note_pkg holds:
  - note codes (NOTE_REST=0, NOTE_C4=1 .. NOTE_B4=12);
  - divisor table at 100 MHz, round(1e8/(2f)): C4 191110, D4 170265, E4 151685, F4 143172, G4 127551, A4 113636, B4 101238, plus sharps;
  - default SONG array;
  - state enum (IDLE, LOAD, PLAY, GAP, NEXT).
- Sub-module note_rom: synchronous-read, 16×7 ROM initialised from note_pkg::SONG.

Test Plan (BEAT_CYC=4, GAP_CYC=2, SONG = {A4/1, rest/2, C4/1, ...}):
- Reset: rst_n=0 for 3 cycles → all outputs 0. After release, no start → stays IDLE for 20 cycles.
- Start pulse at edge N:
  - busy=1 at N+1;
  - tone_en=1 and half_period=113636 for cycles N+2..N+5;
  - silent for 2 cycles;
  - note_idx=1 at N+9.
- Rest entry (idx1): tone_en=0 and half_period=0 for 8 PLAY cycles + 2 GAP cycles. Then idx2 gives half_period=191110 for 4 cycles.
- Completion, SONG_LEN=3, LOOP=0: exactly one done pulse after idx2's NEXT, then IDLE with busy=0. With LOOP=1: no done, and idx returns to 0 with half_period=113636 again.
- stop mid-PLAY of idx0: next edge gives tone_en=0, busy=0, note_idx=0, no done. A new start replays from idx0.
- start and stop in the same cycle from IDLE → stays IDLE. start pulsed during PLAY → note timing unchanged (period still 8 cycles).

Source files
------------

// File: rtl/note_pkg.sv
// Shared types and constants for the melody sequencer: note codes, the
// 100 MHz half-period divisor table, the default song and the FSM states.
package note_pkg;

  localparam int unsigned NOTE_W     = 4;
  localparam int unsigned DUR_W      = 3;
  localparam int unsigned ROM_DEPTH  = 16;
  localparam int unsigned ROM_AW     = 4;
  localparam int unsigned TBL_DIV_W  = 18;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS4  = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS4  = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS4  = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS4  = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS4  = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd12;

  // One ROM word: pitch code and duration in beats (0 plays as 1 beat).
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_NEXT = 3'd4
  } state_t;

  localparam rom_entry_t SONG [ROM_DEPTH] = '{
    '{NOTE_A4,   3'd1},
    '{NOTE_REST, 3'd2},
    '{NOTE_C4,   3'd1},
    '{NOTE_D4,   3'd0},
    '{NOTE_E4,   3'd1},
    '{NOTE_F4,   3'd1},
    '{NOTE_G4,   3'd2},
    '{NOTE_A4,   3'd2},
    '{NOTE_G4,   3'd1},
    '{NOTE_F4,   3'd1},
    '{NOTE_E4,   3'd1},
    '{NOTE_D4,   3'd1},
    '{NOTE_C4,   3'd4},
    '{NOTE_REST, 3'd1},
    '{NOTE_B4,   3'd1},
    '{NOTE_C4,   3'd3}
  };

  // round(1e8 / (2 f)) for each pitch; rests and unused codes give 0.
  function automatic logic [TBL_DIV_W-1:0] note_div(input logic [NOTE_W-1:0] note);
    logic [TBL_DIV_W-1:0] div;
    div = '0;
    case (note)
      NOTE_C4:  div = 18'd191110;
      NOTE_CS4: div = 18'd180386;
      NOTE_D4:  div = 18'd170265;
      NOTE_DS4: div = 18'd160706;
      NOTE_E4:  div = 18'd151685;
      NOTE_F4:  div = 18'd143172;
      NOTE_FS4: div = 18'd135137;
      NOTE_G4:  div = 18'd127551;
      NOTE_GS4: div = 18'd120394;
      NOTE_A4:  div = 18'd113636;
      NOTE_AS4: div = 18'd107258;
      NOTE_B4:  div = 18'd101238;
      default:  div = '0;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/note_rom.sv
// Synchronous-read 16x7 melody ROM holding note_pkg::SONG.
module note_rom
  import note_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ROM_AW-1:0] i_addr,
  output rom_entry_t        o_data
);

  rom_entry_t r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= SONG[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/note_sequencer.sv
// Walks the melody ROM and feeds the tone generator a divisor and enable
// per note, with a silent gap after each note.
module note_sequencer
  import note_pkg::*;
#(
  parameter int unsigned BEAT_CYC = 25_000_000,
  parameter int unsigned GAP_CYC  = 2_000_000,
  parameter int unsigned SONG_LEN = 16,
  parameter int unsigned DIV_W    = 18,
  parameter int unsigned LOOP     = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  output logic [DIV_W-1:0]  o_half_period,
  output logic              o_tone_en,
  output logic              o_busy,
  output logic [ROM_AW-1:0] o_note_idx,
  output logic              o_done
);

  localparam int unsigned BEAT_W = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam int unsigned GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [ROM_AW-1:0] IDX_LAST  = ROM_AW'(SONG_LEN - 1);

  state_t             r_state, w_state_nxt;
  logic [ROM_AW-1:0]  r_note_idx, w_idx_nxt;
  logic [BEAT_W-1:0]  r_beat_cnt, w_beat_nxt;
  logic [DUR_W-1:0]   r_beats_left, w_beats_left_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic [DIV_W-1:0]   r_half_period, w_hp_nxt;
  logic               r_tone_en, w_tone_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  rom_entry_t         w_rom_q;
  logic               w_beat_last;
  logic               w_gap_last;
  logic               w_is_last;
  logic [DIV_W-1:0]   w_div;

  // The ROM is addressed with the index being loaded so its word is ready in LOAD.
  note_rom u_rom (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_addr  (w_idx_nxt),
    .o_data  (w_rom_q)
  );

  assign w_beat_last = (r_beat_cnt == BEAT_LAST);
  assign w_gap_last  = (r_gap_cnt == GAP_LAST);
  assign w_is_last   = (r_note_idx == IDX_LAST);
  assign w_div       = DIV_W'(note_div(w_rom_q.note));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_note_idx    <= '0;
      r_beat_cnt    <= '0;
      r_beats_left  <= '0;
      r_gap_cnt     <= '0;
      r_half_period <= '0;
      r_tone_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_note_idx    <= w_idx_nxt;
      r_beat_cnt    <= w_beat_nxt;
      r_beats_left  <= w_beats_left_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_half_period <= w_hp_nxt;
      r_tone_en     <= w_tone_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; outputs are registered alongside the state.
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_note_idx;
    w_beat_nxt       = r_beat_cnt;
    w_beats_left_nxt = r_beats_left;
    w_gap_nxt        = r_gap_cnt;
    w_hp_nxt         = r_half_period;
    w_tone_nxt       = r_tone_en;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_hp_nxt   = '0;
        w_tone_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        if (i_start && !i_stop) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end

      ST_LOAD: begin
        w_beat_nxt       = '0;
        w_gap_nxt        = '0;
        w_beats_left_nxt = (w_rom_q.dur == 3'd0) ? 3'd1 : w_rom_q.dur;
        w_tone_nxt       = (w_rom_q.note != NOTE_REST);
        w_hp_nxt         = (w_rom_q.note != NOTE_REST) ? w_div : '0;
        w_state_nxt      = ST_PLAY;
      end

      ST_PLAY: begin
        if (w_beat_last) begin
          w_beat_nxt = '0;
          if (r_beats_left == 3'd1) begin
            w_beats_left_nxt = '0;
            w_hp_nxt         = '0;
            w_tone_nxt       = 1'b0;
            if (GAP_CYC > 0) begin
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_NEXT;
              w_done_nxt  = w_is_last && (LOOP == 0);
            end
          end else begin
            w_beats_left_nxt = DUR_W'(r_beats_left - 3'd1);
          end
        end else begin
          w_beat_nxt = BEAT_W'(r_beat_cnt + 1'b1);
        end
      end

      ST_GAP: begin
        if (w_gap_last) begin
          w_gap_nxt   = '0;
          w_state_nxt = ST_NEXT;
          w_done_nxt  = w_is_last && (LOOP == 0);
        end else begin
          w_gap_nxt = GAP_W'(r_gap_cnt + 1'b1);
        end
      end

      ST_NEXT: begin
        if (w_is_last && (LOOP == 0)) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = w_is_last ? '0 : ROM_AW'(r_note_idx + 1'b1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_hp_nxt    = '0;
        w_tone_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Abort takes priority over everything, including a pending done.
    if (i_stop) begin
      w_state_nxt      = ST_IDLE;
      w_idx_nxt        = '0;
      w_beat_nxt       = '0;
      w_beats_left_nxt = '0;
      w_gap_nxt        = '0;
      w_hp_nxt         = '0;
      w_tone_nxt       = 1'b0;
      w_busy_nxt       = 1'b0;
      w_done_nxt       = 1'b0;
    end
  end

  assign o_half_period = r_half_period;
  assign o_tone_en     = r_tone_en;
  assign o_busy        = r_busy;
  assign o_note_idx    = r_note_idx;
  assign o_done        = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: one-shot (3 notes) and looping
// (4 notes, includes a zero-duration entry) instances share stimulus.
module tb_note_sequencer;

  localparam int unsigned DIV_W = 18;

  logic clk;
  logic rst_n;
  logic start;
  logic stop;

  logic [DIV_W-1:0] a_hp, b_hp;
  logic             a_tone, b_tone;
  logic             a_busy, b_busy;
  logic [3:0]       a_idx, b_idx;
  logic             a_done, b_done;

  int n_vec;
  int n_err;

  note_sequencer #(
    .BEAT_CYC(4), .GAP_CYC(2), .SONG_LEN(3), .DIV_W(DIV_W), .LOOP(0)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .o_half_period(a_hp), .o_tone_en(a_tone), .o_busy(a_busy),
    .o_note_idx(a_idx), .o_done(a_done)
  );

  note_sequencer #(
    .BEAT_CYC(4), .GAP_CYC(2), .SONG_LEN(4), .DIV_W(DIV_W), .LOOP(1)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .o_half_period(b_hp), .o_tone_en(b_tone), .o_busy(b_busy),
    .o_note_idx(b_idx), .o_done(b_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) tick();
    n_vec++; if (a_hp !== 18'd0) begin n_err++; $display("FAIL reset_hp got %0d want 0", a_hp); end
    n_vec++; if (a_tone !== 1'b0) begin n_err++; $display("FAIL reset_tone got %0b want 0", a_tone); end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", a_busy); end
    n_vec++; if (a_idx !== 4'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", a_idx); end
    n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", a_done); end
    n_vec++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_b got %0b want 0", b_busy); end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_vec++;
      if (a_busy !== 1'b0 || a_tone !== 1'b0 || a_hp !== 18'd0) begin
        n_err++;
        $display("FAIL idle_hold c=%0d got busy=%0b tone=%0b hp=%0d want 0/0/0", c, a_busy, a_tone, a_hp);
      end
    end
  endtask

  task automatic test_song();
    logic [17:0] e_hp_a, e_hp_b;
    logic        e_tone_a, e_tone_b, e_busy_a, e_busy_b, e_done_a;
    logic [3:0]  e_idx_a, e_idx_b;
    do_reset();
    start = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      tick();
      start = 1'b0;
      e_busy_a = (k <= 28);
      e_tone_a = (k >= 2 && k <= 5) || (k >= 22 && k <= 25);
      e_hp_a   = (k >= 2 && k <= 5) ? 18'd113636 : (k >= 22 && k <= 25) ? 18'd191110 : 18'd0;
      e_idx_a  = (k <= 8) ? 4'd0 : (k <= 20) ? 4'd1 : (k <= 28) ? 4'd2 : 4'd0;
      e_done_a = (k == 28);
      e_busy_b = 1'b1;
      e_tone_b = (k >= 2 && k <= 5) || (k >= 22 && k <= 25) || (k >= 30 && k <= 33) || (k >= 38);
      e_hp_b   = (k >= 2 && k <= 5) ? 18'd113636 : (k >= 22 && k <= 25) ? 18'd191110 :
                 (k >= 30 && k <= 33) ? 18'd170265 : (k >= 38) ? 18'd113636 : 18'd0;
      e_idx_b  = (k <= 8) ? 4'd0 : (k <= 20) ? 4'd1 : (k <= 28) ? 4'd2 : (k <= 36) ? 4'd3 : 4'd0;
      n_vec++;
      if (a_busy !== e_busy_a || a_tone !== e_tone_a || a_hp !== e_hp_a || a_idx !== e_idx_a || a_done !== e_done_a) begin
        n_err++;
        $display("FAIL song_once k=%0d got busy=%0b tone=%0b hp=%0d idx=%0d done=%0b want %0b %0b %0d %0d %0b",
                 k, a_busy, a_tone, a_hp, a_idx, a_done, e_busy_a, e_tone_a, e_hp_a, e_idx_a, e_done_a);
      end
      n_vec++;
      if (b_busy !== e_busy_b || b_tone !== e_tone_b || b_hp !== e_hp_b || b_idx !== e_idx_b || b_done !== 1'b0) begin
        n_err++;
        $display("FAIL song_loop k=%0d got busy=%0b tone=%0b hp=%0d idx=%0d done=%0b want %0b %0b %0d %0d 0",
                 k, b_busy, b_tone, b_hp, b_idx, b_done, e_busy_b, e_tone_b, e_hp_b, e_idx_b);
      end
    end
  endtask

  task automatic test_stop();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_vec++; if (a_tone !== 1'b1) begin n_err++; $display("FAIL stop_pre_tone got %0b want 1", a_tone); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_vec++; if (a_tone !== 1'b0) begin n_err++; $display("FAIL stop_tone got %0b want 0", a_tone); end
    n_vec++; if (a_hp !== 18'd0) begin n_err++; $display("FAIL stop_hp got %0d want 0", a_hp); end
    n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %0b want 0", a_busy); end
    n_vec++; if (a_idx !== 4'd0) begin n_err++; $display("FAIL stop_idx got %0d want 0", a_idx); end
    n_vec++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL stop_busy_b got %0b want 0", b_busy); end
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) begin
        n_err++;
        $display("FAIL stop_quiet c=%0d got done=%0b busy=%0b want 0/0", c, a_done, a_busy);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_vec++;
    if (a_hp !== 18'd113636 || a_tone !== 1'b1 || a_idx !== 4'd0) begin
      n_err++;
      $display("FAIL stop_replay got hp=%0d tone=%0b idx=%0d want 113636 1 0", a_hp, a_tone, a_idx);
    end
  endtask

  task automatic test_start_stop_same();
    do_reset();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (a_busy !== 1'b0 || a_tone !== 1'b0) begin
        n_err++;
        $display("FAIL start_stop_same c=%0d got busy=%0b tone=%0b want 0/0", c, a_busy, a_tone);
      end
      tick();
    end
  endtask

  task automatic test_start_during_play();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_vec++; if (a_tone !== 1'b1) begin n_err++; $display("FAIL restart_k5 tone got %0b want 1", a_tone); end
    tick();
    n_vec++; if (a_tone !== 1'b0) begin n_err++; $display("FAIL restart_k6 tone got %0b want 0", a_tone); end
    tick();
    tick();
    n_vec++;
    if (a_idx !== 4'd0 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_k8 got idx=%0d busy=%0b want 0 1", a_idx, a_busy);
    end
    tick();
    n_vec++; if (a_idx !== 4'd1) begin n_err++; $display("FAIL restart_k9 idx got %0d want 1", a_idx); end
    tick();
    n_vec++;
    if (a_tone !== 1'b0 || a_hp !== 18'd0 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_k10 got tone=%0b hp=%0d busy=%0b want 0 0 1", a_tone, a_hp, a_busy);
    end
  endtask

  task automatic test_reset_mid_note();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (a_tone !== 1'b0 || a_hp !== 18'd0 || a_busy !== 1'b0 || a_idx !== 4'd0 || a_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid got tone=%0b hp=%0d busy=%0b idx=%0d done=%0b want all 0",
               a_tone, a_hp, a_busy, a_idx, a_done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_song();
    test_stop();
    test_start_stop_same();
    test_start_during_play();
    test_reset_mid_note();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
